// File: rtl/rvc_asap_5pl_fpga_in_sync.sv
// Board input conditioning: synchronize and debounce buttons/switches,
// then derive press/change pulses and wrapping press counters.
module rvc_asap_5pl_fpga_in_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       Clock,
  input  logic       Rst,
  input  logic       RawButton_0,
  input  logic       RawButton_1,
  input  logic [9:0] RawSwitch,
  output logic       Button_0,
  output logic       Button_1,
  output logic [9:0] Switch,
  output logic       Button0Press,
  output logic       Button1Press,
  output logic       SwitchChange,
  output logic [7:0] Button0PressCnt,
  output logic [7:0] Button1PressCnt
);

  localparam int N = 12;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]                   raw;
  logic [N-1:0]                   sync_v;
  logic [N-1:0]                   stable;
  logic [N-1:0]                   hist;
  logic [SYNC_STAGES-1:0][N-1:0]  chain;
  logic [N-1:0][CNT_W-1:0]        cnt;
  logic [7:0]                     cnt0;
  logic [7:0]                     cnt1;

  // Bit 0/1 are the buttons, bits 11:2 the switches.
  assign raw    = {RawSwitch, RawButton_1, RawButton_0};
  assign sync_v = chain[SYNC_STAGES-1];

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      stable <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_v[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= sync_v[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      hist <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      hist <= stable;
      if (Button0Press) cnt0 <= cnt0 + 8'd1;
      if (Button1Press) cnt1 <= cnt1 + 8'd1;
    end
  end

  assign Button_0        = stable[0];
  assign Button_1        = stable[1];
  assign Switch          = stable[11:2];
  assign Button0Press    = stable[0] & ~hist[0];
  assign Button1Press    = stable[1] & ~hist[1];
  assign SwitchChange    = |(stable[11:2] ^ hist[11:2]);
  assign Button0PressCnt = cnt0;
  assign Button1PressCnt = cnt1;

endmodule

// File: tb/tb_rvc_asap_5pl_fpga_in_sync.sv
// Directed bench for the input sync/debounce block (SYNC=2, DEBOUNCE=4).
module tb_rvc_asap_5pl_fpga_in_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       rb0;
  logic       rb1;
  logic [9:0] rsw;
  logic       b0;
  logic       b1;
  logic [9:0] sw;
  logic       p0;
  logic       p1;
  logic       swc;
  logic [7:0] c0;
  logic [7:0] c1;

  int checks = 0;
  int errors = 0;

  rvc_asap_5pl_fpga_in_sync #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .Clock(clk),
    .Rst(rst),
    .RawButton_0(rb0),
    .RawButton_1(rb1),
    .RawSwitch(rsw),
    .Button_0(b0),
    .Button_1(b1),
    .Switch(sw),
    .Button0Press(p0),
    .Button1Press(p1),
    .SwitchChange(swc),
    .Button0PressCnt(c0),
    .Button1PressCnt(c1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press0();
    rb0 = 1'b1;
    edges(8);
    rb0 = 1'b0;
    edges(8);
  endtask

  initial begin
    rst = 1'b1;
    rb0 = 1'b0;
    rb1 = 1'b0;
    rsw = '0;
    edges(3);
    check("rst_b0", {31'd0, b0}, 0);
    check("rst_sw", {22'd0, sw}, 0);
    check("rst_c0", {24'd0, c0}, 0);
    rst = 1'b0;
    edges(1);
    check("post_rst_all", {b0, b1, sw, p0, p1, swc, c0, c1}, 0);

    // Clean press on button 0
    rb0 = 1'b1;
    edges(5);
    check("press_early", {31'd0, b0}, 0);
    edges(1);
    check("press_b0", {31'd0, b0}, 1);
    check("press_pulse", {31'd0, p0}, 1);
    check("press_cnt_pre", {24'd0, c0}, 0);
    edges(1);
    check("press_pulse_end", {31'd0, p0}, 0);
    check("press_cnt", {24'd0, c0}, 1);

    // Bouncing button 1: 3 high, 1 low, then held high
    rb1 = 1'b1;
    edges(3);
    rb1 = 1'b0;
    edges(1);
    rb1 = 1'b1;
    edges(5);
    check("bounce_early", {30'd0, b1, p1}, 0);
    check("bounce_cnt0", {24'd0, c1}, 0);
    edges(1);
    check("bounce_b1", {31'd0, b1}, 1);
    check("bounce_pulse", {31'd0, p1}, 1);
    edges(1);
    check("bounce_cnt", {24'd0, c1}, 1);
    edges(3);

    // Release of button 0: no pulse, count kept
    rb0 = 1'b0;
    edges(5);
    check("rel_early", {31'd0, b0}, 1);
    edges(1);
    check("rel_b0", {31'd0, b0}, 0);
    check("rel_nopulse", {31'd0, p0}, 0);
    edges(1);
    check("rel_cnt", {24'd0, c0}, 1);
    rb1 = 1'b0;
    edges(8);
    check("rel1_nopulse", {31'd0, p1}, 0);

    // Two switches change together
    rsw = 10'h201;
    edges(5);
    check("sw_early", {22'd0, sw}, 0);
    edges(1);
    check("sw_val", {22'd0, sw}, 32'h201);
    check("sw_pulse", {31'd0, swc}, 1);
    edges(1);
    check("sw_pulse_end", {31'd0, swc}, 0);

    // Both buttons in the same cycle
    rb0 = 1'b1;
    rb1 = 1'b1;
    edges(6);
    check("both_pulses", {30'd0, p0, p1}, 3);
    edges(1);
    check("both_c0", {24'd0, c0}, 2);
    check("both_c1", {24'd0, c1}, 2);
    rb0 = 1'b0;
    rb1 = 1'b0;
    edges(8);

    // Wrap: 256 presses in total on button 0
    for (int i = 0; i < 253; i++) press0();
    check("wrap_255", {24'd0, c0}, 255);
    press0();
    check("wrap_0", {24'd0, c0}, 0);
    check("wrap_c1", {24'd0, c1}, 2);

    // Async reset while the debounce count sits at 2
    rb0 = 1'b1;
    edges(4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_all", {b0, b1, sw, p0, p1, swc, c0, c1}, 0);
    #2;
    rst = 1'b0;
    edges(5);
    check("arst_early", {31'd0, b0}, 0);
    edges(1);
    check("arst_b0", {31'd0, b0}, 1);
    check("arst_pulse", {31'd0, p0}, 1);
    edges(1);
    check("arst_pulse_end", {31'd0, p0}, 0);
    check("arst_cnt", {24'd0, c0}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
